// File: rtl/ram_model_pkg.sv
// Shared types and parameter helpers for the latency_ram memory model.
package ram_model_pkg;

  // Upper bounds on the field widths carried in a queued request.
  localparam int unsigned MR_ADDR_W = 16;
  localparam int unsigned MR_DATA_W = 16;
  localparam int unsigned MR_TS_W   = 8;

  // Queued write request: address tag, payload and acceptance timestamp.
  typedef struct packed {
    logic [MR_ADDR_W-1:0] address;
    logic [MR_DATA_W-1:0] data;
    logic [MR_TS_W-1:0]   ts;
  } mrqst_s;

  // Queued read request: reads carry no payload.
  typedef struct packed {
    logic [MR_ADDR_W-1:0] address;
    logic [MR_TS_W-1:0]   ts;
  } mrqst_rd_s;

  // Timestamp width large enough that the longest head wait never aliases.
  function automatic int unsigned ts_w(int unsigned latency, int unsigned qdepth);
    return $clog2(latency + qdepth + 1) + 1;
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when a parameter set can be built with the struct widths above.
  function automatic bit params_legal(int unsigned addr_w, int unsigned data_w,
                                      int unsigned depth, int unsigned latency,
                                      int unsigned qdepth);
    bit ok;
    ok = 1'b1;
    if (addr_w == 0 || addr_w > MR_ADDR_W) ok = 1'b0;
    if (data_w == 0 || data_w > MR_DATA_W) ok = 1'b0;
    if (!is_pow2(depth) || depth < 2) ok = 1'b0;
    if (depth > (1 << addr_w)) ok = 1'b0;
    if (latency < 1) ok = 1'b0;
    if (!is_pow2(qdepth) || qdepth < 2) ok = 1'b0;
    if (ts_w(latency, qdepth) > MR_TS_W) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rqst_fifo.sv
// Circular request buffer; caller must not push while full or pop while empty.
module rqst_fifo
  import ram_model_pkg::*;
#(
  parameter int unsigned QDEPTH = 8,
  parameter type entry_t = mrqst_s,
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);

  entry_t             buf_q [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) buf_q[wr_ptr_q] <= push_entry_i;
  end

  // Occupancy follows the push/pop pair; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = buf_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(QDEPTH));

endmodule

// File: rtl/latency_ram.sv
// Fixed-latency request/acknowledge memory with bounded read and write queues.
module latency_ram
  import ram_model_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned QDEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_ret_address,
  output logic              wr_ret_ack,
  output logic              wr_overflow,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic              rd_en,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_ret_data,
  output logic [ADDR_W-1:0] rd_ret_address,
  output logic              rd_ret_ack,
  output logic              rd_overflow
);

  localparam int unsigned TS_W  = ts_w(LATENCY, QDEPTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  if (!params_legal(ADDR_W, DATA_W, DEPTH, LATENCY, QDEPTH)) begin : g_param_check
    $error("latency_ram: illegal parameter set");
  end

  logic [TS_W-1:0]   now_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  mrqst_s            wr_entry_c, wr_head;
  mrqst_rd_s         rd_entry_c, rd_head;
  logic [CNT_W-1:0]  wr_count, rd_count;
  logic              wr_full, rd_full;
  logic              wr_push_c, rd_push_c, wr_pop_c, rd_pop_c;
  logic [TS_W-1:0]   wr_age_c, rd_age_c;
  logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
  logic [DATA_W-1:0] wr_data_c, rd_data_c;

  logic              wr_ret_ack_q, rd_ret_ack_q;
  logic [ADDR_W-1:0] wr_ret_address_q, rd_ret_address_q;
  logic [DATA_W-1:0] rd_ret_data_q;
  logic              wr_overflow_q, rd_overflow_q;

  // Free-running timestamp source.
  always_ff @(posedge clk) begin
    if (reset) now_q <= '0;
    else       now_q <= now_q + TS_W'(1);
  end

  assign wr_ready = !wr_full;
  assign rd_ready = !rd_full;

  // Acceptance, eligibility and write-first read data for both channels.
  always_comb begin
    wr_push_c = wr_en && !wr_full && !reset;
    rd_push_c = rd_en && !rd_full && !reset;

    wr_entry_c         = '0;
    wr_entry_c.address = MR_ADDR_W'(wr_address);
    wr_entry_c.data    = MR_DATA_W'(wr_data);
    wr_entry_c.ts      = MR_TS_W'(now_q);

    rd_entry_c         = '0;
    rd_entry_c.address = MR_ADDR_W'(rd_address);
    rd_entry_c.ts      = MR_TS_W'(now_q);

    // Age is taken modulo 2^TS_W; the wider stored stamp is zero-extended.
    wr_age_c = TS_W'(MR_TS_W'(now_q) - wr_head.ts);
    rd_age_c = TS_W'(MR_TS_W'(now_q) - rd_head.ts);

    wr_pop_c = !reset && (wr_count != '0) && (wr_age_c >= TS_W'(LATENCY));
    rd_pop_c = !reset && (rd_count != '0) && (rd_age_c >= TS_W'(LATENCY));

    wr_idx_c  = IDX_W'(wr_head.address);
    rd_idx_c  = IDX_W'(rd_head.address);
    wr_data_c = DATA_W'(wr_head.data);

    rd_data_c = mem_q[rd_idx_c];
    if (wr_pop_c && (wr_idx_c == rd_idx_c)) rd_data_c = wr_data_c;
  end

  rqst_fifo #(.QDEPTH(QDEPTH), .entry_t(mrqst_s)) u_wr_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (wr_push_c),
    .push_entry_i (wr_entry_c),
    .pop_i        (wr_pop_c),
    .head_o       (wr_head),
    .count_o      (wr_count),
    .full_o       (wr_full)
  );

  rqst_fifo #(.QDEPTH(QDEPTH), .entry_t(mrqst_rd_s)) u_rd_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (rd_push_c),
    .push_entry_i (rd_entry_c),
    .pop_i        (rd_pop_c),
    .head_o       (rd_head),
    .count_o      (rd_count),
    .full_o       (rd_full)
  );

  // Word storage; retained across reset.
  always_ff @(posedge clk) begin
    if (wr_pop_c) mem_q[wr_idx_c] <= wr_data_c;
  end

  // Retire pulses, held return tags/data and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ret_ack_q     <= 1'b0;
      rd_ret_ack_q     <= 1'b0;
      wr_ret_address_q <= '0;
      rd_ret_address_q <= '0;
      rd_ret_data_q    <= '0;
      wr_overflow_q    <= 1'b0;
      rd_overflow_q    <= 1'b0;
    end else begin
      wr_ret_ack_q <= wr_pop_c;
      rd_ret_ack_q <= rd_pop_c;
      if (wr_pop_c) wr_ret_address_q <= ADDR_W'(wr_head.address);
      if (rd_pop_c) begin
        rd_ret_address_q <= ADDR_W'(rd_head.address);
        rd_ret_data_q    <= rd_data_c;
      end
      if (wr_en && wr_full) wr_overflow_q <= 1'b1;
      if (rd_en && rd_full) rd_overflow_q <= 1'b1;
    end
  end

  assign wr_ret_ack     = wr_ret_ack_q;
  assign rd_ret_ack     = rd_ret_ack_q;
  assign wr_ret_address = wr_ret_address_q;
  assign rd_ret_address = rd_ret_address_q;
  assign rd_ret_data    = rd_ret_data_q;
  assign wr_overflow    = wr_overflow_q;
  assign rd_overflow    = rd_overflow_q;

endmodule

// File: tb/tb_latency_ram.sv
// Scoreboard bench for latency_ram: directed scenarios followed by random traffic.
module tb_latency_ram;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned DEP = 1024;
  localparam int unsigned LAT = 16;
  localparam int unsigned QD  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wr_address, rd_address;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_ready;
  logic [AW-1:0] wr_ret_address, rd_ret_address;
  logic          wr_ret_ack, rd_ret_ack;
  logic [DW-1:0] rd_ret_data;
  logic          wr_overflow, rd_overflow;

  latency_ram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_address     (wr_address),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .wr_ret_address (wr_ret_address),
    .wr_ret_ack     (wr_ret_ack),
    .wr_overflow    (wr_overflow),
    .rd_address     (rd_address),
    .rd_en          (rd_en),
    .rd_ready       (rd_ready),
    .rd_ret_data    (rd_ret_data),
    .rd_ret_address (rd_ret_address),
    .rd_ret_ack     (rd_ret_ack),
    .rd_overflow    (rd_overflow)
  );

  always #5 clk = ~clk;

  // Outstanding request: address, data (write payload or expected read data), due edge.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          wr_pend[$];
  exp_t          rd_pend[$];
  logic [DW-1:0] model_mem [DEP];
  int            cyc = 0;
  bit            active = 1'b0;
  bit            m_wr_ovf, m_rd_ovf;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic [DW-1:0] m_rd_data;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc - 1, act, exp);
    end
  endtask

  // Data a read accepted now will return: newest outstanding write to the word, else memory.
  function automatic logic [DW-1:0] expected_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = model_mem[a[9:0]];
    foreach (wr_pend[i]) if (wr_pend[i].addr[9:0] == a[9:0]) v = wr_pend[i].data;
    return v;
  endfunction

  // Reference model: acceptance decisions at each edge.
  always @(posedge clk) begin
    if (reset) begin
      wr_pend.delete();
      rd_pend.delete();
      m_wr_ovf  = 1'b0;
      m_rd_ovf  = 1'b0;
      m_wr_addr = '0;
      m_rd_addr = '0;
      m_rd_data = '0;
      active    = 1'b1;
    end else begin
      if (wr_en) begin
        if (wr_pend.size() < QD) wr_pend.push_back('{addr: wr_address, data: wr_data, due: cyc + LAT});
        else m_wr_ovf = 1'b1;
      end
      if (rd_en) begin
        if (rd_pend.size() < QD) rd_pend.push_back('{addr: rd_address, data: expected_read(rd_address), due: cyc + LAT});
        else m_rd_ovf = 1'b1;
      end
    end
    cyc++;
  end

  // Monitor: retire expected entries and compare against DUT outputs.
  always @(negedge clk) begin
    int k;
    exp_t e;
    k = cyc - 1;
    if (active) begin
      if (wr_ret_ack) begin
        if (wr_pend.size() == 0) check("wr_ack_unexpected", 1, 0);
        else begin
          e = wr_pend.pop_front();
          check("wr_ack_edge", k, e.due);
          model_mem[e.addr[9:0]] = e.data;
          m_wr_addr = e.addr;
        end
      end else if (wr_pend.size() != 0 && wr_pend[0].due <= k) begin
        e = wr_pend.pop_front();
        check("wr_ack_missing", 0, 1);
        model_mem[e.addr[9:0]] = e.data;
        m_wr_addr = e.addr;
      end
      if (rd_ret_ack) begin
        if (rd_pend.size() == 0) check("rd_ack_unexpected", 1, 0);
        else begin
          e = rd_pend.pop_front();
          check("rd_ack_edge", k, e.due);
          m_rd_addr = e.addr;
          m_rd_data = e.data;
        end
      end else if (rd_pend.size() != 0 && rd_pend[0].due <= k) begin
        e = rd_pend.pop_front();
        check("rd_ack_missing", 0, 1);
        m_rd_addr = e.addr;
        m_rd_data = e.data;
      end
      check("wr_ret_address", wr_ret_address, m_wr_addr);
      check("rd_ret_address", rd_ret_address, m_rd_addr);
      check("rd_ret_data", rd_ret_data, m_rd_data);
      check("wr_ready", wr_ready, wr_pend.size() < QD);
      check("rd_ready", rd_ready, rd_pend.size() < QD);
      check("wr_overflow", wr_overflow, m_wr_ovf);
      check("rd_overflow", rd_overflow, m_rd_ovf);
    end
  end

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra);
    wr_en = we; wr_address = wa; wr_data = wd;
    rd_en = re; rd_address = ra;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  logic [9:0] pool [4];

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    wr_address = '0; rd_address = '0; wr_data = '0;
    pool[0] = 10'h010; pool[1] = 10'h020; pool[2] = 10'h005; pool[3] = 10'h3FF;
    foreach (model_mem[i]) model_mem[i] = '0;
    idle(3);
    reset = 1'b0;

    // Single write then read of the same word.
    drive(1, 16'h0010, 16'hBEEF, 0, 0);
    idle(9);
    drive(0, 0, 0, 1, 16'h0010);
    idle(LAT + 4);

    // Nine back-to-back reads: eighth fills the queue, ninth is dropped.
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 16'h0010);
    idle(LAT + 10);
    do_reset(1);

    // Same-cycle write and read of one word.
    drive(1, 16'h0020, 16'h1234, 1, 16'h0020);
    idle(LAT + 4);

    // Aliasing: 0x0405 and 0x0005 share a word.
    drive(1, 16'h0405, 16'h00AA, 0, 0);
    drive(1, 16'hF3FF, 16'h5A5A, 0, 0);
    drive(0, 0, 0, 1, 16'h0005);
    idle(LAT + 4);

    // Reset while writes are in flight; requests during reset are ignored.
    drive(1, 16'h0010, 16'h1111, 0, 0);
    drive(1, 16'h0020, 16'h2222, 0, 0);
    drive(1, 16'h0405, 16'h3333, 0, 0);
    idle(2);
    wr_en = 1'b1; wr_address = 16'h0010; wr_data = 16'hDEAD;
    rd_en = 1'b1; rd_address = 16'h0010;
    do_reset(2);
    wr_en = 1'b0; rd_en = 1'b0;
    drive(0, 0, 0, 1, 16'h0010);
    drive(0, 0, 0, 1, 16'h0020);
    drive(0, 0, 0, 1, 16'h0005);
    idle(LAT + 4);

    // Continuous read stream across several timestamp wraps.
    for (int i = 0; i < 192; i++) drive(0, 0, 0, 1, {6'(i), pool[i % 4]});
    idle(LAT + 4);
    do_reset(1);

    // Random mixed traffic over written words with random alias bits.
    for (int i = 0; i < 600; i++) begin
      bit we, re;
      if (i < 300) begin
        we = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 2) == 0);
      end
      drive(we, {6'($urandom), pool[$urandom_range(0, 3)]}, 16'($urandom),
            re, {6'($urandom), pool[$urandom_range(0, 3)]});
    end
    idle(LAT + 10);

    check("wr_drain", wr_pend.size(), 0);
    check("rd_drain", rd_pend.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/latency_ram.md
# latency_ram

Parametrised, synthesisable successor to the behavioural request/acknowledge memory model. It sits at the memory side of the memory controller and accepts independent read and write request channels. Each accepted request is held in a bounded per-channel queue and retired, in order, exactly `LATENCY` cycles after acceptance with an address-tagged acknowledge. Over-subscription is reported through ready/overflow signals instead of unbounded queues.

## Interface
- `ADDR_W`, 16, request/return address width.
- `DATA_W`, 16, data word width.
- `DEPTH`, 1024, number of words. Must be a power of two and ≤ 2^ADDR_W.
- `LATENCY`, 4, cycles from acceptance to acknowledge. Must be ≥ 1.
- `QDEPTH`, 8, pending-request capacity per channel. Must be a power of two and ≥ 2.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `wr_address` in ADDR_W: write request address.
- `wr_en` in 1: write request valid.
- `wr_data` in DATA_W: write request data.
- `wr_ready` out 1: write queue can accept.
- `wr_ret_address` out ADDR_W: address tag of the retired write.
- `wr_ret_ack` out 1: one-cycle write-retire pulse.
- `wr_overflow` out 1: sticky flag; a write was dropped.
- `rd_address` in ADDR_W: read request address.
- `rd_en` in 1: read request valid.
- `rd_ready` out 1: read queue can accept.
- `rd_ret_data` out DATA_W: read data.
- `rd_ret_address` out ADDR_W: address tag of the retired read.
- `rd_ret_ack` out 1: one-cycle read-retire pulse.
- `rd_overflow` out 1: sticky flag; a read was dropped.

## Operation
- **Free-running cycle counter.** `now` is TS_W bits wide, with TS_W = clog2(LATENCY+QDEPTH+1)+1. It increments every cycle and wraps.
- **Acceptance.** A request is accepted when `x_en && x_ready`. The queue entry is {address, data (writes only), ts=now}.
- **Ready.** `x_ready` = queue count < QDEPTH, computed combinationally from registered count. A push into a full queue is rejected even if a pop happens in the same cycle.
- **Rejection.** `x_en && !x_ready` drops the request and sets `x_overflow`. The flag stays set until reset.
- **Retirement eligibility.** The head entry retires when `(now - ts) mod 2^TS_W >= LATENCY`. Each channel retires at most one entry per cycle, in order.
- **Write retire.** Writes `mem[address mod DEPTH] = data`, pulses `wr_ret_ack`, and drives `wr_ret_address` = the full original address.
- **Read retire.** Returns `mem[address mod DEPTH]`, pulses `rd_ret_ack`, and drives `rd_ret_address` = the full original address.
- **Same-cycle read and write retire to the same word.** Write-first: the read returns the newly written data.
- **Memory contents.** Initialised to 0 at time zero. Reset does not clear them.
- **Push and pop in one cycle.** Allowed. Count is unchanged.

## Timing
- **Reset.** All queues flush and in-flight requests are discarded with no ack. `now` = 0.
- **Output reset values.** `*_ret_ack` = 0, `*_ret_address` = 0, `rd_ret_data` = 0, `*_overflow` = 0, `*_ready` = 1 from the first cycle after reset.
- **Requests during reset.** Ignored.
- **Latency.** A request sampled at edge N produces its ack registered at edge N+LATENCY, i.e. high in the cycle after that edge.
- **Back-to-back requests.** Retire back-to-back.
- **Ack width.** Acks are high for exactly one cycle per retired request. `*_ret_address` and `rd_ret_data` hold their last values when ack is low.
- **Maximum head wait.** LATENCY+QDEPTH cycles, so timestamp wrap never aliases.

## Structure
- Package `ram_model_pkg`:
  - typedef `mrqst_s` {address, data, ts};
  - TS_W helper function;
  - parameter legality checks.
- Sub-module `rqst_fifo`: circular buffer with push, pop, head, count and full. Instantiated once per channel.
- `latency_ram` contains:
  - the `now` counter;
  - eligibility compare;
  - the memory array;
  - the output registers.

## Test plan
- **Single write then read.** Reset, write 0x0010←0xBEEF at cycle 0, read 0x0010 at cycle 10 → `wr_ret_ack` at cycle 4 with address 0x0010; `rd_ret_ack` at cycle 14 with data 0xBEEF and address 0x0010.
- **Fill and overflow.** 9 consecutive reads with QDEPTH=8 and LATENCY=16 → `rd_ready` low after the 8th; the 9th is dropped and `rd_overflow`=1; exactly 8 acks in issue order.
- **Same-cycle write-first.** Write 0x0020←0x1234 and read 0x0020 issued in the same cycle → both acks in the same cycle, read data 0x1234.
- **Address aliasing.** DEPTH=1024: write 0x0405←0x00AA, then read 0x0005 → data 0x00AA, `rd_ret_address`=0x0005.
- **Reset mid-flight.** Issue 3 writes, assert reset 2 cycles later → no acks; memory unchanged; overflow clear; `wr_ready`=1.
- **Counter wrap.** Stream reads every cycle for 3×2^TS_W cycles → every ack arrives exactly LATENCY cycles after its request, with no gaps or duplicates.
